// File: rtl/inst_loader.sv
// inst_loader: packs a valid/ready byte stream MSB-first into 32-bit instruction words,
// writes them to instruction memory and holds the CPU in reset until the image is loaded.
module inst_loader #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DEPTH          = 256,
    parameter int BOOT_ADDR      = 0,
    parameter int RELEASE_CYCLES = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    input  logic                  byte_last,
    output logic                  byte_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [3:0]            mem_be,
    output logic                  cpu_reset,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [15:0]           byte_count
);
    localparam int RW = $clog2(RELEASE_CYCLES) + 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] BOOT = ADDR_WIDTH'(BOOT_ADDR);

    typedef enum logic [2:0] {IDLE, LOAD, WRITE, RELEASE, DONE, ERROR} state_t;

    state_t          state, state_nxt;
    logic [1:0]      lane;
    logic [1:0]      slot;
    logic [3:0]      be;
    logic            last_seen;
    logic [RW-1:0]   rel_cnt;
    logic            accept;
    logic            can_start;

    assign accept    = byte_valid & byte_ready;
    assign can_start = start & (state == IDLE || state == DONE || state == ERROR);
    // lane 0 lands in the top byte, so the byte slot is the inverted lane
    assign slot      = ~lane;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (can_start) state_nxt = LOAD;
        else begin
            case (state)
                LOAD:    if (accept && (lane == 2'd3 || byte_last)) state_nxt = WRITE;
                WRITE:   state_nxt = last_seen ? RELEASE : (mem_addr == LAST_ADDR) ? ERROR : LOAD;
                RELEASE: if (rel_cnt == '0) state_nxt = DONE;
                default: ;
            endcase
        end
    end

    always_comb begin
        byte_ready = state == LOAD;
        mem_we     = state == WRITE;
        mem_be     = mem_we ? be : 4'h0;
        cpu_reset  = state != DONE;
        busy       = state == LOAD || state == WRITE || state == RELEASE;
        done       = state == DONE;
        error      = state == ERROR;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lane       <= '0;
            be         <= '0;
            mem_wdata  <= '0;
            last_seen  <= 1'b0;
            mem_addr   <= BOOT;
            byte_count <= '0;
            rel_cnt    <= '0;
        end else if (can_start) begin
            lane       <= '0;
            be         <= '0;
            mem_wdata  <= '0;
            last_seen  <= 1'b0;
            mem_addr   <= BOOT;
            byte_count <= '0;
        end else begin
            case (state)
                LOAD: if (accept) begin
                    mem_wdata[8*slot +: 8] <= byte_data;
                    be[slot]               <= 1'b1;
                    lane                   <= lane + 2'd1;
                    last_seen              <= byte_last;
                    byte_count             <= byte_count + 16'(byte_count != 16'hFFFF);
                end
                WRITE: begin
                    lane      <= '0;
                    be        <= '0;
                    mem_wdata <= '0;
                    rel_cnt   <= RW'(RELEASE_CYCLES - 1);
                    if (state_nxt == LOAD) mem_addr <= mem_addr + 1'b1;
                end
                RELEASE: if (rel_cnt != '0) rel_cnt <= rel_cnt - 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_inst_loader.sv
// tb_inst_loader: directed tests of the byte-stream loader against a word-level
// expectation queue built from each image, plus literal word checks.
module tb_inst_loader;
    localparam int DEPTH = 4;
    localparam int RC    = 12;

    logic        clk = 1'b0;
    logic        reset, start, byte_valid, byte_last;
    logic [7:0]  byte_data;
    logic        byte_ready, mem_we, cpu_reset, busy, done, error;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [15:0] byte_count;

    always #5 clk = ~clk;

    inst_loader #(.ADDR_WIDTH(8), .DEPTH(DEPTH), .BOOT_ADDR(0), .RELEASE_CYCLES(RC)) dut (
        .clk(clk), .reset(reset), .start(start), .byte_valid(byte_valid),
        .byte_data(byte_data), .byte_last(byte_last), .byte_ready(byte_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error),
        .byte_count(byte_count)
    );

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
        logic [3:0]  be;
        bit          last;
    } wr_t;

    int          checks = 0;
    int          fails = 0;
    wr_t         exp_q[$];
    wr_t         cur;
    logic [31:0] got_data[DEPTH];
    logic [3:0]  got_be[DEPTH];
    int          rel_len = 0;
    bit          rel_armed = 1'b0;
    logic [7:0]  img_a[$], img_b[$], img_big[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        fails++;
        $display("FAIL %s: bounded wait expired", name);
    endtask

    // Model: split an image into 4-byte words, MSB-first, at most DEPTH of them.
    task automatic expect_image(input logic [7:0] img[$], input bit with_last);
        int n = img.size();
        int words = (n + 3) / 4;
        for (int w = 0; w < words && w < DEPTH; w++) begin
            wr_t e;
            e.addr = 8'(w);
            e.data = '0;
            e.be   = '0;
            for (int k = 0; k < 4; k++) begin
                if (4 * w + k < n) begin
                    e.data[31 - 8 * k -: 8] = img[4 * w + k];
                    e.be[3 - k] = 1'b1;
                end
            end
            e.last = with_last && (w == words - 1);
            exp_q.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (mem_we) begin
                if (exp_q.size() == 0) chk("unexpected_write", {24'h0, mem_addr}, 32'hFFFF_FFFF);
                else begin
                    cur = exp_q.pop_front();
                    chk("wr_addr", {24'h0, mem_addr}, {24'h0, cur.addr});
                    chk("wr_data", mem_wdata, cur.data);
                    chk("wr_be", {28'h0, mem_be}, {28'h0, cur.be});
                    got_data[cur.addr[1:0]] = mem_wdata;
                    got_be[cur.addr[1:0]]   = mem_be;
                    rel_armed = cur.last;
                    rel_len   = 0;
                end
            end else begin
                chk("be_idle", {28'h0, mem_be}, 32'h0);
                if (rel_armed && busy) rel_len++;
            end
            if (rel_armed && done) begin
                chk("release_len", rel_len, RC);
                rel_armed = 1'b0;
            end
            chk("cpu_reset_vs_done", {31'h0, cpu_reset}, {31'h0, !done});
        end
    end

    task automatic send(input logic [7:0] b, input bit last, input bit throttle);
        int t = 0;
        if (throttle) begin
            byte_valid = 1'b0;
            @(negedge clk);
        end
        byte_valid = 1'b1;
        byte_data  = b;
        byte_last  = last;
        while (!byte_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!byte_ready) fail_now("ready_timeout");
        @(negedge clk);
        byte_valid = 1'b0;
        byte_last  = 1'b0;
    endtask

    task automatic send_image(input logic [7:0] img[$], input bit with_last, input bit throttle);
        for (int i = 0; i < img.size(); i++) send(img[i], with_last && i == img.size() - 1, throttle);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic start_load();
        pulse_start();
        chk("start_cpu_reset", {31'h0, cpu_reset}, 32'h1);
        chk("start_count", {16'h0, byte_count}, 32'h0);
        chk("start_addr", {24'h0, mem_addr}, 32'h0);
        chk("start_busy", {29'h0, busy, done, error}, 32'h4);
    endtask

    task automatic wait_end(input int lim);
        int t = 0;
        while (!done && !error && t < lim) begin
            @(negedge clk);
            t++;
        end
        if (!done && !error) fail_now("end_timeout");
    endtask

    initial begin
        img_a = '{8'h55, 8'h89, 8'hE5, 8'h83, 8'hEC, 8'h10, 8'hC9, 8'hC3};
        img_b = '{8'h55, 8'h89, 8'hE5, 8'h90, 8'hC3};
        for (int i = 0; i < 17; i++) img_big.push_back(8'(8'h10 + i));
        reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_last = 1'b0; byte_data = '0;
        #2;
        chk("rst_outs", {byte_ready, mem_we, cpu_reset, busy, done, error}, 32'h08);
        chk("rst_addr", {24'h0, mem_addr}, 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_be_count", {12'h0, mem_be, byte_count}, 32'h0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Two full words, then release hold-off
        start_load();
        expect_image(img_a, 1'b1);
        send_image(img_a, 1'b1, 1'b0);
        wait_end(40);
        chk("t1_done", {30'h0, done, cpu_reset}, 32'h2);
        chk("t1_count", {16'h0, byte_count}, 32'd8);
        chk("t1_addr", {24'h0, mem_addr}, 32'd1);
        chk("t1_w0", got_data[0], 32'h5589E583);
        chk("t1_w1", got_data[1], 32'hEC10C9C3);
        chk("t1_be1", {28'h0, got_be[1]}, 32'hF);
        chk("t1_drained", exp_q.size(), 0);

        // Partial final word; a start pulse mid-load must be ignored
        start_load();
        expect_image(img_b, 1'b1);
        send(img_b[0], 1'b0, 1'b0);
        send(img_b[1], 1'b0, 1'b0);
        pulse_start();
        for (int i = 2; i < 5; i++) send(img_b[i], i == 4, 1'b0);
        wait_end(40);
        chk("t2_done", {31'h0, done}, 32'h1);
        chk("t2_count", {16'h0, byte_count}, 32'd5);
        chk("t2_w0", got_data[0], 32'h5589E590);
        chk("t2_w1", got_data[1], 32'hC3000000);
        chk("t2_be1", {28'h0, got_be[1]}, 32'h8);
        chk("t2_drained", exp_q.size(), 0);

        // Throttled source reproduces the same words
        got_data[0] = '0; got_data[1] = '0;
        start_load();
        expect_image(img_a, 1'b1);
        send_image(img_a, 1'b1, 1'b1);
        wait_end(40);
        chk("t3_w0", got_data[0], 32'h5589E583);
        chk("t3_w1", got_data[1], 32'hEC10C9C3);
        chk("t3_count", {16'h0, byte_count}, 32'd8);
        chk("t3_drained", exp_q.size(), 0);

        // Overflow: 17 bytes with no last into a 4-word memory
        start_load();
        expect_image(img_big, 1'b0);
        for (int i = 0; i < 16; i++) send(img_big[i], 1'b0, 1'b0);
        wait_end(10);
        begin
            int ready_seen = 0;
            byte_valid = 1'b1; byte_data = img_big[16];
            for (int i = 0; i < 10; i++) begin
                if (byte_ready) ready_seen++;
                @(negedge clk);
            end
            byte_valid = 1'b0;
            chk("t4_no_ready", ready_seen, 0);
        end
        chk("t4_err", {29'h0, error, done, cpu_reset}, 32'h5);
        chk("t4_count", {16'h0, byte_count}, 32'd16);
        chk("t4_addr", {24'h0, mem_addr}, 32'd3);
        chk("t4_w3", got_data[3], 32'h1C1D1E1F);
        chk("t4_drained", exp_q.size(), 0);

        // Exact fit of DEPTH words with last on the final byte
        img_big.pop_back();
        start_load();
        expect_image(img_big, 1'b1);
        send_image(img_big, 1'b1, 1'b0);
        wait_end(40);
        chk("t5_done", {30'h0, done, error}, 32'h2);
        chk("t5_addr", {24'h0, mem_addr}, 32'd3);
        chk("t5_drained", exp_q.size(), 0);

        // Asynchronous reset in the middle of a word
        start_load();
        send(8'hAA, 1'b0, 1'b0);
        send(8'hBB, 1'b0, 1'b0);
        #1 reset = 1'b1;
        #1;
        chk("t6_outs", {byte_ready, mem_we, cpu_reset, busy, done, error}, 32'h08);
        chk("t6_wdata", mem_wdata, 32'h0);
        chk("t6_addr_count", {8'h0, mem_addr, byte_count}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        start_load();
        expect_image(img_a[0:3], 1'b1);
        send_image(img_a[0:3], 1'b1, 1'b0);
        wait_end(40);
        chk("t6_w0", got_data[0], 32'h5589E583);
        chk("t6_count", {16'h0, byte_count}, 32'd4);
        chk("t6_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
